writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage_pkg.sv | 27 ++
 rtl/writeback_stage_vec_wb_buffer.sv | 67 ++++++
 rtl/writeback_stage.sv | 113 +++++++++++
 tb/tb_writeback_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
`default_nettype none
// ============================================================================
// writeback_stage_pkg : shared widths, FSM encoding and helpers for writeback
// Revision 1.0
// ============================================================================
package writeback_stage_pkg;

    localparam int REG_WIDTH     = 32;
    localparam int VREG_WIDTH    = 64;
    localparam int VREG_ID_WIDTH = 6;
    localparam int PC_WIDTH      = 32;
    localparam int OPCODE_WIDTH  = 8;
    localparam int REG_IDX_WIDTH = 4;

    localparam logic [REG_IDX_WIDTH-1:0] PC_REG_IDX = 4'd15;

    typedef enum logic [0:0] {
        VB_IDLE = 1'b0,
        VB_HOLD = 1'b1
    } vb_state_t;

    function automatic logic [REG_WIDTH-1:0] pc_to_reg(input logic [PC_WIDTH-1:0] pc);
        return REG_WIDTH'(pc);
    endfunction

endpackage : writeback_stage_pkg
`default_nettype wire

// File: rtl/writeback_stage_vec_wb_buffer.sv
`default_nettype none
// ============================================================================
// vec_wb_buffer : one-entry hold buffer for vector writes blocked by the GPU
// Revision 1.0
// ============================================================================
module vec_wb_buffer
    import writeback_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vec_retire,
    input  logic                     gpu_stall,
    input  logic [VREG_ID_WIDTH-1:0] retire_idx,
    input  logic [VREG_WIDTH-1:0]    retire_value,
    output logic                     commit_en,
    output logic [VREG_ID_WIDTH-1:0] commit_idx,
    output logic [VREG_WIDTH-1:0]    commit_value,
    output logic                     pending
);

    vb_state_t                state;
    vb_state_t                next_state;
    logic [VREG_ID_WIDTH-1:0] hold_idx;
    logic [VREG_WIDTH-1:0]    hold_value;

    always_ff @(negedge clk) begin
        if (rst) begin
            state      <= VB_IDLE;
            hold_idx   <= '0;
            hold_value <= '0;
        end else begin
            state <= next_state;
            if (state == VB_IDLE && vec_retire && gpu_stall) begin
                hold_idx   <= retire_idx;
                hold_value <= retire_value;
            end
        end
    end

    always_comb begin
        next_state   = state;
        commit_en    = 1'b0;
        commit_idx   = retire_idx;
        commit_value = retire_value;
        case (state)
            VB_IDLE: begin
                if (vec_retire) begin
                    if (gpu_stall) next_state = VB_HOLD;
                    else           commit_en  = 1'b1;
                end
            end
            VB_HOLD: begin
                commit_idx   = hold_idx;
                commit_value = hold_value;
                if (!gpu_stall) begin
                    commit_en  = 1'b1;
                    next_state = VB_IDLE;
                end
            end
            default: next_state = VB_IDLE;
        endcase
    end

    assign pending = (state == VB_HOLD);

endmodule : vec_wb_buffer
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// writeback_stage : scalar/vector register-file commit, CC and retire counting
// Revision 1.0
// ============================================================================
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int NUM_VREGS = 64
) (
    input  logic                     I_CLOCK,
    input  logic                     I_RESET,
    input  logic                     I_MEM_Valid,
    input  logic [OPCODE_WIDTH-1:0]  I_Opcode,
    input  logic [PC_WIDTH-1:0]      I_PC,
    input  logic [PC_WIDTH-1:0]      I_R15PC,
    input  logic [REG_IDX_WIDTH-1:0] I_DestRegIdx,
    input  logic [REG_WIDTH-1:0]     I_DestValue,
    input  logic                     I_RegWEn,
    input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
    input  logic [VREG_WIDTH-1:0]    I_VecDestValue,
    input  logic                     I_VRegWEn,
    input  logic [2:0]               I_CCValue,
    input  logic                     I_CCWEn,
    input  logic                     I_GPUStallSignal,
    input  logic [REG_IDX_WIDTH-1:0] I_SrcRegIdx1,
    input  logic [REG_IDX_WIDTH-1:0] I_SrcRegIdx2,
    output logic [REG_WIDTH-1:0]     O_SrcValue1,
    output logic [REG_WIDTH-1:0]     O_SrcValue2,
    output logic                     O_WB_RegWEn,
    output logic [REG_IDX_WIDTH-1:0] O_WB_DestRegIdx,
    output logic [REG_WIDTH-1:0]     O_WB_Value,
    output logic [2:0]               O_CCValue,
    output logic                     O_VecPending,
    output logic                     O_Stall,
    output logic [15:0]              O_RetireCount
);

    logic [REG_WIDTH-1:0]     rf  [NUM_REGS];
    logic [VREG_WIDTH-1:0]    vrf [NUM_VREGS];

    logic                     retire;
    logic                     scalar_we;
    logic                     vec_pending;
    logic                     vec_commit_en;
    logic [VREG_ID_WIDTH-1:0] vec_commit_idx;
    logic [VREG_WIDTH-1:0]    vec_commit_value;
    logic                     unused_inputs;

    // Reset blocks retirement so the bypass path never shows a discarded write.
    assign retire    = I_MEM_Valid & ~vec_pending & ~I_RESET;
    assign scalar_we = retire & I_RegWEn;

    assign O_Stall       = vec_pending;
    assign O_VecPending  = vec_pending;
    assign unused_inputs = ^{I_Opcode, I_PC};

    vec_wb_buffer u_vec_wb_buffer (
        .clk          (I_CLOCK),
        .rst          (I_RESET),
        .vec_retire   (retire & I_VRegWEn),
        .gpu_stall    (I_GPUStallSignal),
        .retire_idx   (I_DestVRegIdx),
        .retire_value (I_VecDestValue),
        .commit_en    (vec_commit_en),
        .commit_idx   (vec_commit_idx),
        .commit_value (vec_commit_value),
        .pending      (vec_pending)
    );

    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
            O_CCValue       <= '0;
            O_RetireCount   <= '0;
            O_WB_RegWEn     <= 1'b0;
            O_WB_DestRegIdx <= '0;
            O_WB_Value      <= '0;
        end else begin
            O_WB_RegWEn <= scalar_we;
            if (scalar_we) begin
                rf[I_DestRegIdx] <= I_DestValue;
                O_WB_DestRegIdx  <= I_DestRegIdx;
                O_WB_Value       <= I_DestValue;
            end
            if (retire) begin
                // R15 tracks the retiring PC unless this instruction targets R15 itself.
                if (!(scalar_we && I_DestRegIdx == PC_REG_IDX))
                    rf[PC_REG_IDX] <= pc_to_reg(I_R15PC);
                if (I_CCWEn) O_CCValue <= I_CCValue;
                O_RetireCount <= O_RetireCount + 16'd1;
            end
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            for (int i = 0; i < NUM_VREGS; i++) vrf[i] <= '0;
        end else if (vec_commit_en) begin
            vrf[vec_commit_idx] <= vec_commit_value;
        end
    end

    always_comb begin
        O_SrcValue1 = rf[I_SrcRegIdx1];
        O_SrcValue2 = rf[I_SrcRegIdx2];
        if (scalar_we && I_SrcRegIdx1 == I_DestRegIdx) O_SrcValue1 = I_DestValue;
        if (scalar_we && I_SrcRegIdx2 == I_DestRegIdx) O_SrcValue2 = I_DestValue;
    end

endmodule : writeback_stage
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// tb_writeback_stage : randomized scoreboard bench against a behavioural model
// Revision 1.0
// ============================================================================
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic        clk, rst, mem_valid, reg_wen, vreg_wen, cc_wen, gpu_stall;
    logic [7:0]  opcode;
    logic [31:0] pc, r15pc, dest_value, src1, src2, wb_value;
    logic [3:0]  dest_idx, src1_idx, src2_idx, wb_idx;
    logic [5:0]  dest_vidx;
    logic [63:0] vec_value;
    logic [2:0]  cc_value, cc_out;
    logic        wb_wen, vec_pending, stall;
    logic [15:0] retire_count;

    int checks = 0;
    int errors = 0;

    // Architectural model: plain arrays plus a one-slot pending vector write.
    logic [31:0] mrf  [16];
    logic [63:0] mvrf [64];
    logic [2:0]  mcc;
    logic [15:0] mcount;
    bit          mpend;
    logic [5:0]  mhidx;
    logic [63:0] mhval;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] val;
    } wb_t;
    wb_t wbq[$];

    writeback_stage dut (
        .I_CLOCK(clk), .I_RESET(rst), .I_MEM_Valid(mem_valid),
        .I_Opcode(opcode), .I_PC(pc), .I_R15PC(r15pc),
        .I_DestRegIdx(dest_idx), .I_DestValue(dest_value), .I_RegWEn(reg_wen),
        .I_DestVRegIdx(dest_vidx), .I_VecDestValue(vec_value), .I_VRegWEn(vreg_wen),
        .I_CCValue(cc_value), .I_CCWEn(cc_wen), .I_GPUStallSignal(gpu_stall),
        .I_SrcRegIdx1(src1_idx), .I_SrcRegIdx2(src2_idx),
        .O_SrcValue1(src1), .O_SrcValue2(src2),
        .O_WB_RegWEn(wb_wen), .O_WB_DestRegIdx(wb_idx), .O_WB_Value(wb_value),
        .O_CCValue(cc_out), .O_VecPending(vec_pending), .O_Stall(stall),
        .O_RetireCount(retire_count)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; mem_valid = 1'b0; reg_wen = 1'b0; vreg_wen = 1'b0;
        cc_wen = 1'b0; gpu_stall = 1'b0;
        opcode = 8'($urandom); pc = $urandom; r15pc = $urandom;
        dest_idx = 4'($urandom); dest_value = $urandom;
        dest_vidx = 6'($urandom); vec_value = {$urandom, $urandom};
        cc_value = 3'($urandom);
        src1_idx = 4'($urandom); src2_idx = 4'($urandom);
    endtask

    // Called with inputs already driven just after a rising edge; the DUT
    // commits on the following falling edge.
    task automatic cycle(input bit quiet);
        bit          ret;
        logic [31:0] e1, e2;
        int          bad;
        #1;
        ret = mem_valid && !mpend && !rst;
        if (!quiet) begin
            chk("stall", 64'(stall), 64'(mpend));
            chk("vec_pending", 64'(vec_pending), 64'(mpend));
            e1 = (ret && reg_wen && src1_idx == dest_idx) ? dest_value : mrf[src1_idx];
            e2 = (ret && reg_wen && src2_idx == dest_idx) ? dest_value : mrf[src2_idx];
            chk("src1", 64'(src1), 64'(e1));
            chk("src2", 64'(src2), 64'(e2));
            chk("cc", 64'(cc_out), 64'(mcc));
            chk("retire_count", 64'(retire_count), 64'(mcount));
        end
        if (rst) begin
            foreach (mrf[i])  mrf[i]  = '0;
            foreach (mvrf[i]) mvrf[i] = '0;
            mcc = '0; mcount = '0; mpend = 1'b0;
        end else if (mpend) begin
            if (!gpu_stall) begin
                mvrf[mhidx] = mhval;
                mpend = 1'b0;
            end
        end else if (ret) begin
            if (!(reg_wen && dest_idx == 4'd15)) mrf[15] = r15pc;
            if (reg_wen) begin
                mrf[dest_idx] = dest_value;
                wbq.push_back('{dest_idx, dest_value});
            end
            if (cc_wen) mcc = cc_value;
            mcount = mcount + 16'd1;
            if (vreg_wen) begin
                if (gpu_stall) begin
                    mpend = 1'b1; mhidx = dest_vidx; mhval = vec_value;
                end else begin
                    mvrf[dest_vidx] = vec_value;
                end
            end
        end
        @(posedge clk);
        #1;
        if (!quiet) begin
            bad = 0;
            for (int i = 0; i < 16; i++) if (dut.rf[i] !== mrf[i]) bad++;
            chk("rf_contents", 64'(bad), 64'd0);
            bad = 0;
            for (int i = 0; i < 64; i++) if (dut.vrf[i] !== mvrf[i]) bad++;
            chk("vrf_contents", 64'(bad), 64'd0);
        end
    endtask

    // Scoreboard monitor: every scalar retire must appear on O_WB_* one edge later.
    always @(posedge clk) begin
        wb_t e;
        if (wb_wen === 1'b1) begin
            checks++;
            if (wbq.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected actual idx=%h val=%h required none", wb_idx, wb_value);
            end else begin
                e = wbq.pop_front();
                if (wb_idx !== e.idx || wb_value !== e.val) begin
                    errors++;
                    $display("FAIL wb_data actual idx=%h val=%h required idx=%h val=%h",
                             wb_idx, wb_value, e.idx, e.val);
                end
            end
        end else if (wbq.size() != 0) begin
            checks++;
            errors++;
            e = wbq.pop_front();
            $display("FAIL wb_missing actual wen=%b required idx=%h val=%h", wb_wen, e.idx, e.val);
        end
    end

    initial begin
        logic [15:0] saved_count;
        foreach (mrf[i])  mrf[i]  = '0;
        foreach (mvrf[i]) mvrf[i] = '0;
        mcc = '0; mcount = '0; mpend = 1'b0; mhidx = '0; mhval = '0;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        cycle(1'b1);
        idle_inputs(); rst = 1'b1; mem_valid = 1'b1; reg_wen = 1'b1;
        cycle(1'b0);
        chk("reset_wb_wen", 64'(wb_wen), 64'd0);
        chk("reset_wb_idx", 64'(wb_idx), 64'd0);
        chk("reset_wb_value", 64'(wb_value), 64'd0);
        chk("reset_count", 64'(retire_count), 64'd0);

        // Same-cycle bypass of R3 and one-edge WB latency.
        idle_inputs(); mem_valid = 1'b1; reg_wen = 1'b1;
        dest_idx = 4'd3; dest_value = 32'h1234; src1_idx = 4'd3;
        cycle(1'b0);
        chk("wb_value_r3", 64'(wb_value), 64'h1234);

        // Scalar write to R15 beats the PC shadow.
        idle_inputs(); mem_valid = 1'b1; reg_wen = 1'b1;
        dest_idx = 4'd15; dest_value = 32'h0040; r15pc = 32'h0022;
        cycle(1'b0);
        chk("r15_scalar_wins", 64'(dut.rf[15]), 64'h0040);

        // Vector write held by GPU; scalar and CC parts commit at capture.
        idle_inputs(); mem_valid = 1'b1; reg_wen = 1'b1; dest_idx = 4'd7;
        dest_value = 32'hABCD; cc_wen = 1'b1; cc_value = 3'd5;
        vreg_wen = 1'b1; dest_vidx = 6'd5; vec_value = 64'hDEADBEEFCAFEF00D; gpu_stall = 1'b1;
        cycle(1'b0);
        chk("hold_scalar_r7", 64'(dut.rf[7]), 64'hABCD);
        for (int k = 0; k < 3; k++) begin
            idle_inputs(); gpu_stall = 1'b1; mem_valid = 1'b1; reg_wen = 1'b1;
            vreg_wen = 1'b1; cc_wen = 1'b1;
            cycle(1'b0);
            chk("hold_stall", 64'(stall), 64'd1);
        end
        chk("hold_vrf5_not_yet", dut.vrf[5], 64'd0);
        idle_inputs();
        cycle(1'b0);
        chk("hold_vrf5_commit", dut.vrf[5], 64'hDEADBEEFCAFEF00D);
        chk("hold_released", 64'(stall), 64'd0);

        // Reset while holding discards the buffered write.
        idle_inputs(); rst = 1'b1;
        cycle(1'b0);
        idle_inputs(); mem_valid = 1'b1; vreg_wen = 1'b1; dest_vidx = 6'd5;
        vec_value = 64'h0123456789ABCDEF; gpu_stall = 1'b1;
        cycle(1'b0);
        idle_inputs(); rst = 1'b1; gpu_stall = 1'b1; mem_valid = 1'b1; reg_wen = 1'b1;
        cycle(1'b0);
        chk("reset_hold_stall", 64'(stall), 64'd0);
        idle_inputs();
        cycle(1'b0);
        chk("reset_hold_vrf5", dut.vrf[5], 64'd0);

        // Write enables without MEM_Valid change nothing.
        saved_count = mcount;
        idle_inputs(); reg_wen = 1'b1; cc_wen = 1'b1; vreg_wen = 1'b1; cc_value = 3'd7;
        cycle(1'b0);
        chk("novalid_count", 64'(retire_count), 64'(saved_count));
        chk("novalid_cc", 64'(cc_out), 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            rst       = ($urandom_range(0, 59) == 0);
            mem_valid = ($urandom_range(0, 3) != 0);
            reg_wen   = $urandom_range(0, 1) == 1;
            vreg_wen  = $urandom_range(0, 2) == 0;
            cc_wen    = $urandom_range(0, 1) == 1;
            gpu_stall = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 2) == 0) src1_idx = dest_idx;
            if ($urandom_range(0, 2) == 0) src2_idx = dest_idx;
            cycle(1'b0);
        end

        // Retire counter wraparound.
        idle_inputs(); rst = 1'b1;
        cycle(1'b0);
        for (int n = 0; n < 65535; n++) begin
            idle_inputs(); mem_valid = 1'b1;
            cycle(1'b1);
        end
        chk("count_ffff", 64'(retire_count), 64'hFFFF);
        idle_inputs(); mem_valid = 1'b1;
        cycle(1'b0);
        chk("count_wrap", 64'(retire_count), 64'h0000);

        idle_inputs();
        cycle(1'b0);
        cycle(1'b0);
        chk("wb_queue_drained", 64'(wbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_writeback_stage
`default_nettype wire
